// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, bit timing, deserialisation,
// parity/stop checking and a one-cycle result strobe per frame.
module uart_rx_fsm #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [4:0]        Prescale,
    input  logic              S_Data,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled,
    input  logic              Sampled_bit,
    output logic [4:0]        edge_count,
    output logic              S_EN,
    output logic [DATA_W-1:0] P_Data,
    output logic              Data_valid,
    output logic              Parity_error,
    output logic              Stop_error
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nx;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] sr;
    logic              par_err;
    logic              wrap;

    assign S_EN = (state != IDLE);
    assign wrap = (state != IDLE) && (edge_count == Prescale - 5'd1);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!S_Data) state_nx = START;
            START: begin
                if (sampled && Sampled_bit) state_nx = IDLE;
                else if (wrap)              state_nx = DATA;
            end
            DATA:    if (wrap && bit_idx == LAST_BIT) state_nx = PAR_EN ? PARITY : STOP;
            PARITY:  if (wrap) state_nx = STOP;
            // Leave on the stop strobe, not the wrap, so the next start edge is not missed.
            STOP:    if (sampled) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter is zero in every IDLE cycle and in the first START cycle.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            edge_count <= '0;
        else if (state == IDLE || state_nx == IDLE || wrap)
            edge_count <= '0;
        else
            edge_count <= edge_count + 5'd1;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            bit_idx <= '0;
        else if (state == START && wrap)
            bit_idx <= '0;
        else if (state == DATA && wrap)
            bit_idx <= bit_idx + 1'b1;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sr      <= '0;
            par_err <= 1'b0;
        end else if (state == IDLE && !S_Data) begin
            sr      <= '0;
            par_err <= 1'b0;
        end else if (state == DATA && sampled) begin
            sr <= {Sampled_bit, sr[DATA_W-1:1]};
        end else if (state == PARITY && sampled) begin
            if (Sampled_bit != ((^sr) ^ PAR_TYP)) par_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            P_Data       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
        end else begin
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
            if (state == STOP && sampled) begin
                Stop_error   <= ~Sampled_bit;
                Parity_error <= par_err;
                if (Sampled_bit && !par_err) begin
                    Data_valid <= 1'b1;
                    P_Data     <= sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a small 3-sample majority sampler model.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [4:0] Prescale;
    logic       S_Data;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled;
    logic       Sampled_bit;
    logic [4:0] edge_count;
    logic       S_EN;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Parity_error;
    logic       Stop_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int dv_n = 0, pe_n = 0, se_n = 0;
    int dv_cyc = 0, dv_prev = 0, pe_cyc = 0, se_cyc = 0;
    int m_dv, m_pe, m_se;
    logic s0, s1;

    uart_rx_fsm #(.DATA_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .Prescale(Prescale), .S_Data(S_Data),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled(sampled),
        .Sampled_bit(Sampled_bit), .edge_count(edge_count), .S_EN(S_EN),
        .P_Data(P_Data), .Data_valid(Data_valid), .Parity_error(Parity_error),
        .Stop_error(Stop_error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Sampler: votes samples at edges P/2, P/2+1, P/2+2; strobe one cycle later.
    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            s0 <= 1'b1; s1 <= 1'b1; sampled <= 1'b0; Sampled_bit <= 1'b1;
        end else begin
            sampled <= S_EN && (edge_count == (Prescale >> 1) + 5'd2);
            if (S_EN && edge_count == (Prescale >> 1))        s0 <= S_Data;
            if (S_EN && edge_count == (Prescale >> 1) + 5'd1) s1 <= S_Data;
            if (S_EN && edge_count == (Prescale >> 1) + 5'd2)
                Sampled_bit <= (s0 & s1) | (s0 & S_Data) | (s1 & S_Data);
        end
    end

    always @(negedge CLK) begin
        if (Data_valid)   begin dv_n <= dv_n + 1; dv_prev <= dv_cyc; dv_cyc <= cyc; end
        if (Parity_error) begin pe_n <= pe_n + 1; pe_cyc <= cyc; end
        if (Stop_error)   begin se_n <= se_n + 1; se_cyc <= cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        m_dv = dv_n; m_pe = pe_n; m_se = se_n;
    endtask

    task automatic send_frame(input int p, input logic [7:0] d, input bit pen,
                              input bit pbit, input bit stop_bit);
        Prescale = 5'(p);
        PAR_EN   = pen;
        t_start  = cyc;
        S_Data   = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            S_Data = d[i];
            tick(p);
        end
        if (pen) begin
            S_Data = pbit;
            tick(p);
        end
        S_Data = stop_bit;
        tick(p);
        S_Data = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; Prescale = 5'd8; S_Data = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        tick(3);
        chk("rst_edge", 32'(edge_count), 0);
        chk("rst_sen", 32'(S_EN), 0);
        chk("rst_pdata", 32'(P_Data), 32'h00);
        chk("rst_dv", 32'(Data_valid), 0);
        chk("rst_pe", 32'(Parity_error), 0);
        chk("rst_se", 32'(Stop_error), 0);
        Reset = 1'b1;
        tick(4);

        // Good frame, P=8, no parity
        mark();
        send_frame(8, 8'hA5, 0, 0, 1);
        tick(12);
        chk("good_dv_n", 32'(dv_n - m_dv), 1);
        chk("good_lat", 32'(dv_cyc - t_start), 81);
        chk("good_pdata", 32'(P_Data), 32'hA5);
        chk("good_err", 32'((pe_n - m_pe) + (se_n - m_se)), 0);

        // Even parity, correct then wrong parity bit
        PAR_TYP = 1'b0;
        mark();
        send_frame(16, 8'h3C, 1, 0, 1);
        tick(20);
        chk("evn_dv_n", 32'(dv_n - m_dv), 1);
        chk("evn_pdata", 32'(P_Data), 32'h3C);
        chk("evn_pe_n", 32'(pe_n - m_pe), 0);
        mark();
        send_frame(16, 8'h3C, 1, 1, 1);
        tick(20);
        chk("evnbad_pe_n", 32'(pe_n - m_pe), 1);
        chk("evnbad_dv_n", 32'(dv_n - m_dv), 0);
        chk("evnbad_se_n", 32'(se_n - m_se), 0);
        chk("evnbad_pdata", 32'(P_Data), 32'h3C);

        // Stop error, no parity
        mark();
        send_frame(8, 8'h01, 0, 0, 0);
        tick(12);
        chk("stop_se_n", 32'(se_n - m_se), 1);
        chk("stop_dv_n", 32'(dv_n - m_dv), 0);
        chk("stop_pe_n", 32'(pe_n - m_pe), 0);
        chk("stop_pdata", 32'(P_Data), 32'h3C);

        // Odd parity wrong (expected 0, sent 1) plus stop error
        PAR_TYP = 1'b1;
        mark();
        send_frame(8, 8'h01, 1, 1, 0);
        tick(12);
        chk("odd_pe_n", 32'(pe_n - m_pe), 1);
        chk("odd_se_n", 32'(se_n - m_se), 1);
        chk("odd_same_cyc", 32'(pe_cyc - se_cyc), 0);
        chk("odd_lat", 32'(pe_cyc - t_start), 89);
        chk("odd_dv_n", 32'(dv_n - m_dv), 0);
        PAR_TYP = 1'b0;

        // Start glitch: line low for two cycles only
        Prescale = 5'd8; PAR_EN = 1'b0;
        mark();
        S_Data = 1'b0;
        tick(2);
        S_Data = 1'b1;
        tick(6);
        chk("gl_sen_hi", 32'(S_EN), 1);
        tick(1);
        chk("gl_sen_lo", 32'(S_EN), 0);
        tick(20);
        chk("gl_flags", 32'((dv_n - m_dv) + (pe_n - m_pe) + (se_n - m_se)), 0);
        mark();
        send_frame(8, 8'h55, 0, 0, 1);
        tick(12);
        chk("gl55_dv_n", 32'(dv_n - m_dv), 1);
        chk("gl55_pdata", 32'(P_Data), 32'h55);

        // Back-to-back frames at P=16, no idle gap
        mark();
        send_frame(16, 8'h12, 0, 0, 1);
        send_frame(16, 8'h34, 0, 0, 1);
        tick(20);
        chk("b2b_dv_n", 32'(dv_n - m_dv), 2);
        chk("b2b_space", 32'(dv_cyc - dv_prev), 160);
        chk("b2b_pdata", 32'(P_Data), 32'h34);
        chk("b2b_err", 32'((pe_n - m_pe) + (se_n - m_se)), 0);

        // Reset during data bit 4
        mark();
        Prescale = 5'd8;
        S_Data = 1'b0;
        tick(8);
        S_Data = 1'b1;
        tick(35);
        chk("mid_sen_pre", 32'(S_EN), 1);
        Reset = 1'b0;
        #1;
        chk("mid_edge", 32'(edge_count), 0);
        chk("mid_sen", 32'(S_EN), 0);
        chk("mid_pdata", 32'(P_Data), 32'h00);
        chk("mid_dv", 32'(Data_valid), 0);
        tick(2);
        Reset = 1'b1;
        tick(5);
        chk("mid_flags", 32'((dv_n - m_dv) + (pe_n - m_pe) + (se_n - m_se)), 0);
        mark();
        send_frame(8, 8'hFF, 0, 0, 1);
        tick(12);
        chk("ff_dv_n", 32'(dv_n - m_dv), 1);
        chk("ff_pdata", 32'(P_Data), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
